// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 receive path: default bit timing,
// bit FSM state encoding and the bit-period helper.
package rs232_pkg;

    localparam int unsigned FREQUENCY_DEF    = 32'd50_000_000;
    localparam int unsigned SPEED_DEF        = 32'd9600;
    localparam int unsigned TIMEOUT_BITS_DEF = 32'd20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Clock cycles per bit period
    function automatic int unsigned bit_ticks(input int unsigned freq, input int unsigned speed);
        return freq / speed;
    endfunction

endpackage

// File: rtl/rs232_package_receiver_if.sv
// Serial line in, recovered byte/package strobes out.
// The receiver takes the slave view; line driver / consumer takes the master view.
interface rs232_package_receiver_if;
    logic        rx;
    logic [7:0]  byte_o;
    logic        byte_valid;
    logic [15:0] package_o;
    logic        package_valid;
    logic        frame_error;
    logic        pair_timeout;

    modport slave (
        input  rx,
        output byte_o, byte_valid, package_o, package_valid, frame_error, pair_timeout
    );

    modport master (
        output rx,
        input  byte_o, byte_valid, package_o, package_valid, frame_error, pair_timeout
    );
endinterface

// File: rtl/rs232_byte_rx.sv
// 8N1 byte receiver: rx synchronizer, bit FSM and bit-period tick counter.
// Strobes are decoded from the stop-sample cycle so the parent can register them.
//
//   state    | meaning
//   ST_IDLE  | line idle; start accepted on rx_s 1->0 once armed
//   ST_START | waiting half a bit to confirm the start bit
//   ST_DATA  | sampling 8 data bits, one per bit period, LSB first
//   ST_STOP  | waiting one bit period to sample the stop bit
module rs232_byte_rx
    import rs232_pkg::*;
#(
    parameter int unsigned FREQUENCY = FREQUENCY_DEF,
    parameter int unsigned SPEED     = SPEED_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       good_o,
    output logic       err_o,
    output logic       start_o,
    output logic       idle_o
);

    localparam int unsigned BIT_TICKS  = bit_ticks(FREQUENCY, SPEED);
    localparam int unsigned HALF_TICKS = BIT_TICKS / 2;
    localparam int          CNT_W      = $clog2(BIT_TICKS);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_TICKS - 1);

    logic             sync1_q;
    logic             rx_s_q;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             armed_q;
    logic             stop_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            rx_s_q  <= sync1_q;
            case (state_q)
                ST_IDLE: begin
                    if (rx_s_q) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        armed_q <= 1'b0;
                        state_q <= ST_START;
                        cnt_q   <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (cnt_q == '0) begin
                        if (!rx_s_q) begin
                            state_q   <= ST_DATA;
                            cnt_q     <= BIT_LOAD;
                            bit_cnt_q <= '0;
                        end else begin
                            // glitch: line already high again, so re-arm directly
                            state_q <= ST_IDLE;
                            armed_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        cnt_q   <= BIT_LOAD;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        // a good stop bit already counts as the high level that arms the next frame
                        armed_q <= rx_s_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stop_hit = (state_q == ST_STOP) && (cnt_q == '0);
    assign good_o   = stop_hit && rx_s_q;
    assign err_o    = stop_hit && !rx_s_q;
    assign data_o   = shift_q;
    assign start_o  = (state_q == ST_IDLE) && !rx_s_q && armed_q;
    assign idle_o   = (state_q == ST_IDLE);

endmodule

// File: rtl/rs232_package_receiver.sv
// Reassembles pairs of received bytes (high byte first) into 16-bit coded packages,
// dropping a lone high byte if the low byte does not follow in time.
module rs232_package_receiver
    import rs232_pkg::*;
#(
    parameter int unsigned FREQUENCY    = FREQUENCY_DEF,
    parameter int unsigned SPEED        = SPEED_DEF,
    parameter int unsigned TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
    input  logic                     CLK_i,
    input  logic                     reset_n,
    rs232_package_receiver_if.slave  bus
);

    localparam int unsigned BIT_TICKS = bit_ticks(FREQUENCY, SPEED);
    localparam int unsigned TO_TICKS  = TIMEOUT_BITS * BIT_TICKS;
    localparam int          TO_W      = $clog2(TO_TICKS);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TO_TICKS - 1);

    logic [7:0]      rx_byte;
    logic            rx_good;
    logic            rx_err;
    logic            rx_start;
    logic            rx_idle;

    logic [7:0]      byte_q;
    logic            byte_valid_q;
    logic [15:0]     package_q;
    logic            package_valid_q;
    logic            frame_error_q;
    logic            pair_timeout_q;
    logic            half_full_q;
    logic [7:0]      high_q;
    logic [TO_W-1:0] to_cnt_q;

    rs232_byte_rx #(
        .FREQUENCY (FREQUENCY),
        .SPEED     (SPEED)
    ) u_byte_rx (
        .clk_i   (CLK_i),
        .rst_i   (reset_n),
        .rx_i    (bus.rx),
        .data_o  (rx_byte),
        .good_o  (rx_good),
        .err_o   (rx_err),
        .start_o (rx_start),
        .idle_o  (rx_idle)
    );

    always_ff @(posedge CLK_i or posedge reset_n) begin
        if (reset_n) begin
            byte_q          <= '0;
            byte_valid_q    <= 1'b0;
            package_q       <= '0;
            package_valid_q <= 1'b0;
            frame_error_q   <= 1'b0;
            pair_timeout_q  <= 1'b0;
            half_full_q     <= 1'b0;
            high_q          <= '0;
            to_cnt_q        <= TO_LOAD;
        end else begin
            byte_valid_q    <= 1'b0;
            package_valid_q <= 1'b0;
            frame_error_q   <= 1'b0;
            pair_timeout_q  <= 1'b0;
            // byte completion is checked first so it always beats a coincident timeout
            if (rx_good) begin
                byte_q       <= rx_byte;
                byte_valid_q <= 1'b1;
                to_cnt_q     <= TO_LOAD;
                if (half_full_q) begin
                    package_q       <= {high_q, rx_byte};
                    package_valid_q <= 1'b1;
                    half_full_q     <= 1'b0;
                end else begin
                    high_q      <= rx_byte;
                    half_full_q <= 1'b1;
                end
            end else if (rx_err) begin
                frame_error_q <= 1'b1;
                half_full_q   <= 1'b0;
                to_cnt_q      <= TO_LOAD;
            end else if (!half_full_q || !rx_idle || rx_start) begin
                to_cnt_q <= TO_LOAD;
            end else if (to_cnt_q == '0) begin
                pair_timeout_q <= 1'b1;
                half_full_q    <= 1'b0;
                to_cnt_q       <= TO_LOAD;
            end else begin
                to_cnt_q <= to_cnt_q - 1'b1;
            end
        end
    end

    assign bus.byte_o        = byte_q;
    assign bus.byte_valid    = byte_valid_q;
    assign bus.package_o     = package_q;
    assign bus.package_valid = package_valid_q;
    assign bus.frame_error   = frame_error_q;
    assign bus.pair_timeout  = pair_timeout_q;

endmodule

// File: tb/tb_rs232_package_receiver.sv
// Directed and randomized frames against a pairing/timeout reference model;
// every pulse, its timing and payload are compared with the model.
module tb_rs232_package_receiver;

    localparam int unsigned FREQ    = 160;
    localparam int unsigned SPD     = 10;
    localparam int unsigned TOB     = 20;
    localparam int unsigned BT      = FREQ / SPD;
    // line fall to result pulse: 3 (sync + edge) + BT/2 + 9*BT
    localparam int unsigned LAT     = 3 + BT / 2 + 9 * BT;
    localparam int unsigned TO_SAFE = TOB * BT + 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    logic [7:0]  exp_bytes[$];
    logic [7:0]  got_bytes[$];
    logic [15:0] exp_pkgs[$];
    logic [15:0] got_pkgs[$];
    int unsigned exp_cyc[$];
    int unsigned got_cyc[$];
    int          exp_fe = 0, got_fe = 0, exp_to = 0, got_to = 0;
    bit          m_pending = 1'b0;
    logic [7:0]  m_high = '0;

    rs232_package_receiver_if bus ();

    rs232_package_receiver #(
        .FREQUENCY    (FREQ),
        .SPEED        (SPD),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .CLK_i   (clk),
        .reset_n (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.byte_valid === 1'b1) begin
            got_bytes.push_back(bus.byte_o);
            got_cyc.push_back(cyc);
        end
        if (bus.frame_error === 1'b1) begin
            got_cyc.push_back(cyc);
            got_fe++;
        end
        if (bus.package_valid === 1'b1) begin
            got_pkgs.push_back(bus.package_o);
            chk("pkg_with_byte_valid", 32'(bus.byte_valid), 32'd1);
        end
        if (bus.pair_timeout === 1'b1) got_to++;
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_byte_o"}, 32'(bus.byte_o), 32'd0);
        chk({tag, "_byte_valid"}, 32'(bus.byte_valid), 32'd0);
        chk({tag, "_package_o"}, 32'(bus.package_o), 32'd0);
        chk({tag, "_package_valid"}, 32'(bus.package_valid), 32'd0);
        chk({tag, "_frame_error"}, 32'(bus.frame_error), 32'd0);
        chk({tag, "_pair_timeout"}, 32'(bus.pair_timeout), 32'd0);
    endtask

    // abort_at >= 0 asserts reset at that cycle offset into the frame
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit jitter,
                              input int abort_at);
        int          bnd[11];
        int          seg;
        int unsigned t0;
        logic        lvl;
        bnd[0]  = 0;
        bnd[10] = 10 * BT;
        for (int i = 1; i < 10; i++)
            bnd[i] = i * BT + (jitter ? (int'($urandom_range(0, 6)) - 3) : 0);
        @(posedge clk); #1;
        t0 = cyc;
        for (int c = 0; c < 10 * BT; c++) begin
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                chk_outputs_zero("mid_frame_reset");
                bus.rx = 1'b1;
                m_pending = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                return;
            end
            seg = 0;
            for (int i = 1; i < 10; i++) if (c >= bnd[i]) seg = i;
            if (seg == 0)      lvl = 1'b0;
            else if (seg == 9) lvl = stop_ok;
            else               lvl = b[seg-1];
            bus.rx = lvl;
            @(posedge clk); #1;
        end
        bus.rx = 1'b1;
        exp_cyc.push_back(t0 + LAT);
        if (stop_ok) begin
            exp_bytes.push_back(b);
            if (m_pending) begin
                exp_pkgs.push_back({m_high, b});
                m_pending = 1'b0;
            end else begin
                m_high    = b;
                m_pending = 1'b1;
            end
        end else begin
            exp_fe++;
            m_pending = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
        if (n >= int'(TO_SAFE) && m_pending) begin
            exp_to++;
            m_pending = 1'b0;
        end
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_n_bytes"}, 32'(got_bytes.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            chk({tag, "_byte"}, 32'(got_bytes[i]), 32'(exp_bytes[i]));
        chk({tag, "_n_pkgs"}, 32'(got_pkgs.size()), 32'(exp_pkgs.size()));
        for (int i = 0; i < got_pkgs.size() && i < exp_pkgs.size(); i++)
            chk({tag, "_package"}, 32'(got_pkgs[i]), 32'(exp_pkgs[i]));
        chk({tag, "_n_pulses"}, 32'(got_cyc.size()), 32'(exp_cyc.size()));
        for (int i = 0; i < got_cyc.size() && i < exp_cyc.size(); i++)
            chk({tag, "_pulse_cycle"}, got_cyc[i], exp_cyc[i]);
        chk({tag, "_frame_errors"}, 32'(got_fe), 32'(exp_fe));
        chk({tag, "_timeouts"}, 32'(got_to), 32'(exp_to));
        got_bytes.delete(); exp_bytes.delete();
        got_pkgs.delete();  exp_pkgs.delete();
        got_cyc.delete();   exp_cyc.delete();
        got_fe = 0; exp_fe = 0; got_to = 0; exp_to = 0;
    endtask

    initial begin
        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;
        idle(5);

        // back-to-back pair
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        idle(10);
        check_results("pair_a53c");

        // pending high byte dropped, 3C becomes the new high byte
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        idle(int'(TOB * BT) + 5);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        send_frame(8'h11, 1'b1, 1'b0, -1);
        idle(10);
        check_results("timeout");

        // bad stop bit, then a clean pair
        send_frame(8'h81, 1'b0, 1'b0, -1);
        idle(5);
        send_frame(8'h12, 1'b1, 1'b0, -1);
        send_frame(8'h34, 1'b1, 1'b0, -1);
        idle(10);
        check_results("frame_error");

        // start-bit glitch of 5 cycles
        @(posedge clk); #1;
        bus.rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.rx = 1'b1;
        idle(30);
        check_results("glitch_quiet");
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        idle(10);
        check_results("after_glitch");

        // reset during data bit 4 with a high byte pending
        send_frame(8'h77, 1'b1, 1'b0, -1);
        send_frame(8'hEE, 1'b1, 1'b0, int'(5 * BT + BT / 2));
        send_frame(8'h55, 1'b1, 1'b0, -1);
        send_frame(8'hAA, 1'b1, 1'b0, -1);
        idle(10);
        check_results("reset_mid_frame");

        // jittered bit edges
        send_frame(8'h96, 1'b1, 1'b1, -1);
        send_frame(8'h69, 1'b1, 1'b1, -1);
        idle(10);
        check_results("jitter");

        for (int k = 0; k < 40; k++) begin
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), 1'b1, -1);
            if ($urandom_range(0, 9) == 0) idle(int'(TO_SAFE) + 5);
            else                           idle(int'($urandom_range(0, 12)));
        end
        idle(10);
        check_results("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rs232_package_receiver.md
# rs232_package_receiver

Receive-side counterpart of the RS-232 transmit path: samples the serial line (8N1, LSB first), recovers bytes, and reassembles each pair of consecutive bytes into the 16-bit coded package produced by `Coder_RS_232`. The first byte is the high half. Output feeds the downstream package decoder and error-correction stage. Bit timing is derived from the same FREQUENCY/SPEED parameters as `Transmitter`.

## Interface
- FREQUENCY, 32'd50_000_000, clock frequency in Hz
- SPEED, 32'd9600, baud rate; BIT_TICKS = FREQUENCY/SPEED, HALF_TICKS = BIT_TICKS/2 (integer division)
- TIMEOUT_BITS, 32'd20, idle bit periods allowed between the high and low byte before the half-package is dropped
- CLK_i  in  1  system clock, single clock domain
- reset_n  in  1  asynchronous, active-high reset (name kept for consistency with `Transmitter`)
- rx  in  1  serial line, idle high, asynchronous to CLK_i
- byte_o  out  8  last good byte; reset 8'h00
- byte_valid  out  1  one-cycle pulse when byte_o is updated; reset 0
- package_o  out  16  {high byte, low byte}; reset 16'h0000
- package_valid  out  1  one-cycle pulse when package_o is updated; reset 0
- frame_error  out  1  one-cycle pulse when the stop bit is sampled low; reset 0
- pair_timeout  out  1  one-cycle pulse when a pending high byte is dropped; reset 0

## Operation
- rx passes through a 2-FF synchronizer (reset value 1). All logic below uses the synchronized value rx_s.
- Bit FSM states:
  - IDLE -> START on a 1->0 transition of rx_s, with the tick counter cleared. A transition is only armed after rx_s has been seen high for at least 1 cycle since the last frame.
  - START: at HALF_TICKS, if rx_s=0 go to DATA and clear the counter; otherwise treat it as a glitch and return to IDLE with no output.
  - DATA: sample every BIT_TICKS. Shift right with rx_s inserted at bit 7. Go to STOP after 8 samples.
  - STOP: sample after BIT_TICKS. If 1, the byte is good. If 0, pulse frame_error, discard the byte, and clear the pending pair. Either way return to IDLE.
- Pairing: a `half_full` flag.
  - Good byte with half_full=0: store the byte as the high half and set the flag.
  - Good byte with half_full=1: load package_o = {high, byte}, pulse package_valid, clear the flag.
- Timeout: a counter runs while half_full=1 and the FSM is in IDLE. It clears on any start detection.
  - On reaching TIMEOUT_BITS*BIT_TICKS: pulse pair_timeout, clear half_full.
  - A byte completing in the same cycle as the timeout wins; no timeout fires.
- byte_o/byte_valid pulse for every good byte, paired or not.
- Reset mid-frame: all state and outputs return to reset values immediately. The FSM resumes in IDLE waiting for rx_s high.

## Timing
- Cycle E: rx_s first seen low.
  - Start check at E+HALF_TICKS.
  - Data bit k sampled at E+HALF_TICKS+(k+1)*BIT_TICKS, k=0..7.
  - Stop bit sampled at E+HALF_TICKS+9*BIT_TICKS.
- byte_valid, package_valid, and frame_error are registered: they go high 1 cycle after the stop sample, for exactly 1 cycle.
- package_valid coincides with byte_valid of the low byte.
- Line-to-E latency: 2 cycles (synchronizer) plus 1 cycle (edge detect).
- Back-to-back frames: a start edge is accepted 1 cycle after the stop sample.

## Structure
- Shared package `rs232_pkg`:
  - FREQUENCY/SPEED defaults
  - bit FSM state encoding (IDLE/START/DATA/STOP, 2 bits)
  - BIT_TICKS helper function
- Sub-module `rs232_byte_rx`: synchronizer, bit FSM, tick counter. Outputs byte + good/error strobes.
- Top `rs232_package_receiver`: pairing flag, timeout counter, output registers.

## Test plan
All scenarios use FREQUENCY=160, SPEED=10 (BIT_TICKS=16).
- Send 8'hA5 then 8'h3C back-to-back -> byte_valid twice (A5, 3C); package_valid once with package_o=16'hA53C; no error pulses.
- Send 8'hA5, hold idle 20*16+5 cycles, send 8'h3C -> pair_timeout pulse after the timeout; no package_valid; 3C becomes the pending high byte.
- Send 8'h81 with the stop bit forced 0 -> frame_error at stop sample+1; no byte_valid; a following pair 12,34 yields package_o=16'h1234.
- rx low pulse of 5 cycles -> no outputs, FSM back in IDLE; a following valid frame is received correctly.
- Assert reset_n during bit 4 of a frame -> all outputs 0 immediately; after release, a fresh pair 55,AA yields 16'h55AA.
- Sample-point check: drive bits with edges jittered by ±3 cycles -> bytes still decoded correctly.
